// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, FSM states,
// opcode classes and one-hot ALU op bit positions.
package ctrl_pkg;

  localparam int ALU_W = 13;

  // alu_op bit positions, MSB first: {AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT}
  localparam int ALU_AND  = 12;
  localparam int ALU_OR   = 11;
  localparam int ALU_ADD  = 10;
  localparam int ALU_SUB  = 9;
  localparam int ALU_MUL  = 8;
  localparam int ALU_DIV  = 7;
  localparam int ALU_SHR  = 6;
  localparam int ALU_SHRA = 5;
  localparam int ALU_SHL  = 4;
  localparam int ALU_ROR  = 3;
  localparam int ALU_ROL  = 2;
  localparam int ALU_NEG  = 1;
  localparam int ALU_NOT  = 0;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  // LDI shares the immediate-class microsequence (constant + rb through the ADD path)
  typedef enum logic [3:0] {
    C_R, C_IMM, C_UN, C_MD, C_LD, C_ST, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
  } op_class_t;

  function automatic op_class_t op_class(input logic [4:0] opc);
    op_class_t c;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:       c = C_R;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:      c = C_IMM;
      OP_NEG, OP_NOT:                        c = C_UN;
      OP_MUL, OP_DIV:                        c = C_MD;
      OP_LD:                                 c = C_LD;
      OP_ST:                                 c = C_ST;
      OP_MFHI:                               c = C_MFHI;
      OP_MFLO:                               c = C_MFLO;
      OP_NOP:                                c = C_NOP;
      OP_HALT:                               c = C_HALT;
      default:                               c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [ALU_W-1:0] alu_sel(input logic [4:0] opc);
    logic [ALU_W-1:0] v;
    v = '0;
    case (opc)
      OP_AND, OP_ANDI:                  v[ALU_AND]  = 1'b1;
      OP_OR, OP_ORI:                    v[ALU_OR]   = 1'b1;
      OP_ADD, OP_ADDI, OP_LDI,
      OP_LD, OP_ST:                     v[ALU_ADD]  = 1'b1;
      OP_SUB:                           v[ALU_SUB]  = 1'b1;
      OP_MUL:                           v[ALU_MUL]  = 1'b1;
      OP_DIV:                           v[ALU_DIV]  = 1'b1;
      OP_SHR:                           v[ALU_SHR]  = 1'b1;
      OP_SHRA:                          v[ALU_SHRA] = 1'b1;
      OP_SHL:                           v[ALU_SHL]  = 1'b1;
      OP_ROR:                           v[ALU_ROR]  = 1'b1;
      OP_ROL:                           v[ALU_ROL]  = 1'b1;
      OP_NEG:                           v[ALU_NEG]  = 1'b1;
      OP_NOT:                           v[ALU_NOT]  = 1'b1;
      default:                          v = '0;
    endcase
    return v;
  endfunction

  function automatic state_t last_state(input op_class_t c);
    state_t s;
    case (c)
      C_UN:         s = S_T4;
      C_R, C_IMM:   s = S_T5;
      C_MD:         s = S_T6;
      C_LD, C_ST:   s = S_T7;
      default:      s = S_T3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/reg_sel_decode.sv
// Register field to one-hot strobe decoder; fields beyond NUM_REGS select nothing.
module reg_sel_decode #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          sel,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bit
    assign onehot[g] = en && (32'(sel) == g);
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/decode/execute control unit for the 32-bit bus datapath.
// Build option ILLEGAL_TRAP_EN: undefined opcodes halt instead of running as NOP.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS       = 16,
  parameter bit START_ON_RESET = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic                hi_in,
  output logic                lo_in,
  output logic                hi_out,
  output logic                lo_out,
  output logic                zhigh_out,
  output logic                zlow_out,
  output logic                pc_in,
  output logic                inc_pc,
  output logic                ir_in,
  output logic                mar_in,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                y_in,
  output logic                z_in,
  output logic                c_out,
  output logic                read,
  output logic                mem_write,
  output logic [ALU_W-1:0]    alu_op,
  output logic                busy,
  output logic                halted,
  output logic                illegal
);

  state_t     state;
  logic [4:0] opc_q;
  op_class_t  cls;
  logic [3:0] ra, rb, rc;
  logic       mem_wait;
  logic       r_in_en, r_out_en, alu_en;
  logic [3:0] r_out_sel;
  logic       unused_ir;

  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];
  assign cls       = op_class(opc_q);
  assign mem_wait  = (state == S_T6 && cls == C_LD) || (state == S_T7 && cls == C_ST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      opc_q   <= OP_NOP;
      illegal <= 1'b0;
    end else begin
      // illegal is a one-cycle pulse unless the sequencer parked in HALT on it
      illegal <= illegal && (state == S_HALT);
      case (state)
        S_IDLE:   if (run || START_ON_RESET) state <= S_FETCH0;
        S_FETCH0: state <= S_FETCH1;
        S_FETCH1: if (mem_ready) state <= S_FETCH2;
        S_FETCH2: state <= S_DECODE;
        S_DECODE: begin
          opc_q <= ir[31:27];
          case (op_class(ir[31:27]))
            C_NOP:  state <= S_FETCH0;
            C_HALT: state <= S_HALT;
            C_ILL: begin
              illegal <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
              state   <= S_HALT;
`else
              state   <= S_FETCH0;
`endif
            end
            default: state <= S_T3;
          endcase
        end
        S_T3, S_T4, S_T5, S_T6, S_T7: begin
          if (!mem_wait || mem_ready) begin
            if (state == last_state(cls)) state <= S_FETCH0;
            else                          state <= state_t'(state + 4'd1);
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode: strobes depend only on the registered state, latched opcode and IR fields
  always_comb begin
    hi_in = 1'b0;  lo_in = 1'b0;  hi_out = 1'b0;  lo_out = 1'b0;
    zhigh_out = 1'b0;  zlow_out = 1'b0;
    pc_in = 1'b0;  inc_pc = 1'b0;  ir_in = 1'b0;  mar_in = 1'b0;
    mdr_in = 1'b0;  mdr_out = 1'b0;  y_in = 1'b0;  z_in = 1'b0;  c_out = 1'b0;
    read = 1'b0;  mem_write = 1'b0;
    r_in_en = 1'b0;  r_out_en = 1'b0;  r_out_sel = rb;  alu_en = 1'b0;
    case (state)
      S_FETCH0: begin inc_pc = 1'b1; pc_in = 1'b1; mar_in = 1'b1; end
      S_FETCH1: begin read = 1'b1; mdr_in = 1'b1; end
      S_FETCH2: begin mdr_out = 1'b1; ir_in = 1'b1; end
      S_T3: case (cls)
        C_R, C_IMM, C_LD, C_ST: begin r_out_en = 1'b1; y_in = 1'b1; end
        C_UN:   begin r_out_en = 1'b1; alu_en = 1'b1; z_in = 1'b1; end
        C_MD:   begin r_out_en = 1'b1; r_out_sel = ra; y_in = 1'b1; end
        C_MFHI: begin hi_out = 1'b1; r_in_en = 1'b1; end
        C_MFLO: begin lo_out = 1'b1; r_in_en = 1'b1; end
        default: ;
      endcase
      S_T4: case (cls)
        C_R:    begin r_out_en = 1'b1; r_out_sel = rc; alu_en = 1'b1; z_in = 1'b1; end
        C_IMM, C_LD, C_ST: begin c_out = 1'b1; alu_en = 1'b1; z_in = 1'b1; end
        C_UN:   begin zlow_out = 1'b1; r_in_en = 1'b1; end
        C_MD:   begin r_out_en = 1'b1; alu_en = 1'b1; z_in = 1'b1; end
        default: ;
      endcase
      S_T5: case (cls)
        C_R, C_IMM: begin zlow_out = 1'b1; r_in_en = 1'b1; end
        C_LD, C_ST: begin zlow_out = 1'b1; mar_in = 1'b1; end
        C_MD:       begin zlow_out = 1'b1; lo_in = 1'b1; end
        default: ;
      endcase
      S_T6: case (cls)
        C_MD: begin zhigh_out = 1'b1; hi_in = 1'b1; end
        C_LD: begin read = 1'b1; mdr_in = 1'b1; end
        C_ST: begin r_out_en = 1'b1; r_out_sel = ra; mdr_in = 1'b1; end
        default: ;
      endcase
      S_T7: case (cls)
        C_LD: begin mdr_out = 1'b1; r_in_en = 1'b1; end
        C_ST: mem_write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

  assign alu_op = alu_en ? alu_sel(opc_q) : '0;
  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

  reg_sel_decode #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .sel    (ra),
    .en     (r_in_en),
    .onehot (r_in)
  );

  reg_sel_decode #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .sel    (r_out_sel),
    .en     (r_out_en),
    .onehot (r_out)
  );

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench: per-instruction expected strobe sequences built from the opcode tables,
// compared against the DUT every cycle, plus literal pins on selected cycles.
module tb_ctrl_sequencer;

  localparam int NR = 16;

  localparam logic [19:0] M_HI_IN   = 20'd1 << 0;
  localparam logic [19:0] M_LO_IN   = 20'd1 << 1;
  localparam logic [19:0] M_HI_OUT  = 20'd1 << 2;
  localparam logic [19:0] M_LO_OUT  = 20'd1 << 3;
  localparam logic [19:0] M_ZH      = 20'd1 << 4;
  localparam logic [19:0] M_ZL      = 20'd1 << 5;
  localparam logic [19:0] M_PC_IN   = 20'd1 << 6;
  localparam logic [19:0] M_INC_PC  = 20'd1 << 7;
  localparam logic [19:0] M_IR_IN   = 20'd1 << 8;
  localparam logic [19:0] M_MAR_IN  = 20'd1 << 9;
  localparam logic [19:0] M_MDR_IN  = 20'd1 << 10;
  localparam logic [19:0] M_MDR_OUT = 20'd1 << 11;
  localparam logic [19:0] M_Y_IN    = 20'd1 << 12;
  localparam logic [19:0] M_Z_IN    = 20'd1 << 13;
  localparam logic [19:0] M_C_OUT   = 20'd1 << 14;
  localparam logic [19:0] M_RD      = 20'd1 << 15;
  localparam logic [19:0] M_WR      = 20'd1 << 16;
  localparam logic [19:0] M_BUSY    = 20'd1 << 17;
  localparam logic [19:0] M_HALTED  = 20'd1 << 18;
  localparam logic [19:0] M_ILL     = 20'd1 << 19;

  logic clk = 1'b0;
  logic reset, run, mem_ready;
  logic [31:0] ir;
  logic [NR-1:0] r_in, r_out;
  logic hi_in, lo_in, hi_out, lo_out, zhigh_out, zlow_out;
  logic pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out, y_in, z_in, c_out;
  logic read, mem_write, busy, halted, illegal;
  logic [12:0] alu_op;

  ctrl_sequencer #(.NUM_REGS(NR), .START_ON_RESET(1'b0)) dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir), .mem_ready(mem_ready),
    .r_in(r_in), .r_out(r_out),
    .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
    .zhigh_out(zhigh_out), .zlow_out(zlow_out),
    .pc_in(pc_in), .inc_pc(inc_pc), .ir_in(ir_in), .mar_in(mar_in),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .y_in(y_in), .z_in(z_in), .c_out(c_out),
    .read(read), .mem_write(mem_write), .alu_op(alu_op),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [19:0] dut_fl;
  logic [64:0] dut_cw;
  assign dut_fl = {illegal, halted, busy, mem_write, read, c_out, z_in, y_in, mdr_out, mdr_in,
                   mar_in, ir_in, inc_pc, pc_in, zlow_out, zhigh_out, lo_out, hi_out, lo_in, hi_in};
  assign dut_cw = {dut_fl, r_in, r_out, alu_op};

  typedef struct {
    string       nm;
    logic        mr;
    logic        rn;
    logic [31:0] ir;
    logic [19:0] fl;
    logic [15:0] rin, rout;
    logic [12:0] alu;
    logic        pin;
    logic [15:0] pin_rin, pin_rout;
    logic [12:0] pin_alu;
  } ent_t;

  ent_t seq[$];
  ent_t cur;
  logic cur_v;
  logic [31:0] cur_ir;
  logic pend_ill, in_halt;
  int nvec, nerr;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] oh(input logic [3:0] r);
    logic [15:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a, b, c);
    return {op, a, b, c, 15'd0};
  endfunction

  // Position in the {AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT} list
  function automatic logic [12:0] alu_of(input logic [4:0] op);
    int idx;
    logic [12:0] v;
    idx = -1;
    case (op)
      5'b00101, 5'b01101:                   idx = 0;
      5'b00110, 5'b01110:                   idx = 1;
      5'b00011, 5'b01100, 5'b00001,
      5'b00000, 5'b00010:                   idx = 2;
      5'b00100: idx = 3;
      5'b10000: idx = 4;
      5'b01111: idx = 5;
      5'b01001: idx = 6;
      5'b01010: idx = 7;
      5'b01011: idx = 8;
      5'b00111: idx = 9;
      5'b01000: idx = 10;
      5'b10001: idx = 11;
      5'b10010: idx = 12;
      default:  idx = -1;
    endcase
    v = '0;
    if (idx >= 0) v[12 - idx] = 1'b1;
    return v;
  endfunction

  task automatic push(input string nm, input logic rn, input logic mr, input logic [19:0] fl,
                      input logic [15:0] rin, input logic [15:0] rout, input logic [12:0] alu);
    ent_t e;
    e.nm = nm; e.rn = rn; e.mr = mr; e.ir = cur_ir; e.fl = fl;
    e.rin = rin; e.rout = rout; e.alu = alu;
    e.pin = 1'b0; e.pin_rin = '0; e.pin_rout = '0; e.pin_alu = '0;
    seq.push_back(e);
  endtask

  task automatic px(input string nm, input logic mr, input logic [19:0] fl,
                    input logic [15:0] rin, input logic [15:0] rout, input logic [12:0] alu);
    push(nm, 1'b1, mr, fl, rin, rout, alu);
  endtask

  task automatic pin(input int i, input logic [15:0] rin, input logic [15:0] rout, input logic [12:0] alu);
    ent_t e;
    e = seq[i];
    e.pin = 1'b1; e.pin_rin = rin; e.pin_rout = rout; e.pin_alu = alu;
    seq[i] = e;
  endtask

  // Expected cycle-by-cycle behaviour of one instruction; mi is mem_ready outside wait cycles
  task automatic gen(input logic [31:0] irv, input int fwait, input int mwait, input logic mi);
    logic [4:0]  op;
    logic [15:0] a, b, c;
    logic [12:0] al;
    logic [19:0] B;
    op = irv[31:27]; a = oh(irv[26:23]); b = oh(irv[22:19]); c = oh(irv[18:15]);
    al = alu_of(op); B = M_BUSY; cur_ir = irv;
    px("FETCH0", mi, B | M_INC_PC | M_PC_IN | M_MAR_IN | (pend_ill ? M_ILL : 20'd0), '0, '0, '0);
    pend_ill = 1'b0;
    for (int i = 0; i < fwait; i++) px("FETCH1 wait", 1'b0, B | M_RD | M_MDR_IN, '0, '0, '0);
    px("FETCH1", 1'b1, B | M_RD | M_MDR_IN, '0, '0, '0);
    px("FETCH2", mi, B | M_MDR_OUT | M_IR_IN, '0, '0, '0);
    px("DECODE", mi, B, '0, '0, '0);
    if (op inside {[5'd3:5'd11]}) begin
      px("R T3", mi, B | M_Y_IN, '0, b, '0);
      px("R T4", mi, B | M_Z_IN, '0, c, al);
      px("R T5", mi, B | M_ZL, a, '0, '0);
    end else if (op inside {5'd1, 5'd12, 5'd13, 5'd14}) begin
      px("I T3", mi, B | M_Y_IN, '0, b, '0);
      px("I T4", mi, B | M_C_OUT | M_Z_IN, '0, '0, al);
      px("I T5", mi, B | M_ZL, a, '0, '0);
    end else if (op inside {5'd17, 5'd18}) begin
      px("U T3", mi, B | M_Z_IN, '0, b, al);
      px("U T4", mi, B | M_ZL, a, '0, '0);
    end else if (op inside {5'd15, 5'd16}) begin
      px("MD T3", mi, B | M_Y_IN, '0, a, '0);
      px("MD T4", mi, B | M_Z_IN, '0, b, al);
      px("MD T5", mi, B | M_ZL | M_LO_IN, '0, '0, '0);
      px("MD T6", mi, B | M_ZH | M_HI_IN, '0, '0, '0);
    end else if (op inside {5'd0, 5'd2}) begin
      px("M T3", mi, B | M_Y_IN, '0, b, '0);
      px("M T4", mi, B | M_C_OUT | M_Z_IN, '0, '0, al);
      px("M T5", mi, B | M_ZL | M_MAR_IN, '0, '0, '0);
      if (op == 5'd0) begin
        for (int i = 0; i < mwait; i++) px("LD T6 wait", 1'b0, B | M_RD | M_MDR_IN, '0, '0, '0);
        px("LD T6", 1'b1, B | M_RD | M_MDR_IN, '0, '0, '0);
        px("LD T7", mi, B | M_MDR_OUT, a, '0, '0);
      end else begin
        px("ST T6", mi, B | M_MDR_IN, '0, a, '0);
        for (int i = 0; i < mwait; i++) px("ST T7 wait", 1'b0, B | M_WR, '0, '0, '0);
        px("ST T7", 1'b1, B | M_WR, '0, '0, '0);
      end
    end else if (op == 5'd24) begin
      px("MFHI T3", mi, B | M_HI_OUT, a, '0, '0);
    end else if (op == 5'd25) begin
      px("MFLO T3", mi, B | M_LO_OUT, a, '0, '0);
    end else if (op == 5'd26) begin
      // NOP: straight back to fetch
    end else if (op == 5'd27) begin
      for (int i = 0; i < 3; i++) px("HALT", mi, M_HALTED, '0, '0, '0);
      in_halt = 1'b1;
    end else begin
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) px("TRAP", mi, M_HALTED | M_ILL, '0, '0, '0);
      in_halt = 1'b1;
`else
      pend_ill = 1'b1;
`endif
    end
  endtask

  task automatic run_n(input int n);
    int k;
    k = n;
    while (seq.size() > 0 && k != 0) begin
      @(posedge clk); #2;
      cur = seq.pop_front();
      mem_ready = cur.mr; run = cur.rn; ir = cur.ir;
      cur_v = 1'b1;
      k--;
    end
    @(negedge clk); #1;
    cur_v = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; run = 1'b0; mem_ready = 1'b0;
    #1;
    chk("reset outputs", dut_cw, 65'd0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    pend_ill = 1'b0; in_halt = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cur_v) begin
      chk(cur.nm, dut_cw, {cur.fl, cur.rin, cur.rout, cur.alu});
      if (cur.pin) chk({"pin ", cur.nm}, {20'd0, r_in, r_out, alu_op},
                       {20'd0, cur.pin_rin, cur.pin_rout, cur.pin_alu});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    nvec = 0; nerr = 0; cur_v = 1'b0; pend_ill = 1'b0; in_halt = 1'b0;
    ir = '0; cur_ir = '0; reset = 1'b0; run = 1'b0; mem_ready = 1'b0;
    do_reset();

    push("IDLE", 1'b0, 1'b1, '0, '0, '0, '0);
    push("IDLE", 1'b1, 1'b1, '0, '0, '0, '0);
    base = seq.size();
    gen(mk_ir(5'b00011, 4'd2, 4'd4, 4'd5), 0, 0, 1'b1);
    pin(base + 4, 16'h0000, 16'h0010, 13'h0000);
    pin(base + 5, 16'h0000, 16'h0020, 13'h0400);
    pin(base + 6, 16'h0004, 16'h0000, 13'h0000);
    gen(mk_ir(5'b00100, 4'd1, 4'd2, 4'd3), 2, 0, 1'b0);
    gen(mk_ir(5'b01100, 4'd6, 4'd7, 4'd0), 0, 0, 1'b1);
    gen(mk_ir(5'b00001, 4'd8, 4'd0, 4'd0), 0, 0, 1'b0);
    gen(mk_ir(5'b10001, 4'd9, 4'd10, 4'd0), 0, 0, 1'b1);
    gen(mk_ir(5'b10010, 4'd15, 4'd14, 4'd0), 1, 0, 1'b0);
    gen(mk_ir(5'b01010, 4'd0, 4'd13, 4'd12), 0, 0, 1'b1);
    gen(mk_ir(5'b01000, 4'd11, 4'd12, 4'd13), 0, 0, 1'b0);
    gen(mk_ir(5'b01101, 4'd3, 4'd5, 4'd0), 0, 0, 1'b0);
    base = seq.size();
    gen(mk_ir(5'b10000, 4'd3, 4'd1, 4'd0), 0, 0, 1'b0);
    pin(base + 4, 16'h0000, 16'h0008, 13'h0000);
    pin(base + 5, 16'h0000, 16'h0002, 13'h0100);
    gen(mk_ir(5'b01111, 4'd4, 4'd6, 4'd0), 0, 0, 1'b1);
    gen(mk_ir(5'b00000, 4'd7, 4'd9, 4'd0), 0, 4, 1'b0);
    gen(mk_ir(5'b11000, 4'd10, 4'd0, 4'd0), 0, 0, 1'b0);
    gen(mk_ir(5'b11001, 4'd11, 4'd0, 4'd0), 0, 0, 1'b1);
    gen(mk_ir(5'b11010, 4'd0, 4'd0, 4'd0), 0, 0, 1'b0);
    gen(mk_ir(5'b00010, 4'd6, 4'd1, 4'd0), 0, 2, 1'b0);
    gen(mk_ir(5'b11111, 4'd1, 4'd2, 4'd3), 0, 0, 1'b0);
    if (!in_halt) begin
      gen(mk_ir(5'b11010, 4'd0, 4'd0, 4'd0), 0, 0, 1'b0);
      gen(mk_ir(5'b00011, 4'd1, 4'd2, 4'd3), 0, 0, 1'b1);
    end
    run_n(-1);

    // Reset asserted in the middle of a store's memory wait
    do_reset();
    push("IDLE", 1'b1, 1'b0, '0, '0, '0, '0);
    gen(mk_ir(5'b00010, 4'd5, 4'd2, 4'd0), 0, 20, 1'b0);
    run_n(11);
    seq.delete();
    do_reset();

    push("IDLE", 1'b1, 1'b0, '0, '0, '0, '0);
    gen(mk_ir(5'b00011, 4'd15, 4'd0, 4'd1), 0, 0, 1'b0);
    gen(mk_ir(5'b11011, 4'd0, 4'd0, 4'd0), 0, 0, 1'b1);
    run_n(-1);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Hardwired control unit that sequences the 32-bit bus datapath: it fetches instructions, decodes IR, and steps through per-opcode T-states. In each state it drives the register in/out strobes, the ALU op one-hot, and the PC, MAR, MDR, Y and Z enables. It sits beside the datapath with one external memory-ready handshake. All control outputs are Moore decodes of the registered state plus the IR fields.

Parameters:
NUM_REGS, 16, general registers; width of r_in/r_out
START_ON_RESET, 0, 1 = leave IDLE on the first clock after reset without waiting for run

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; low forces IDLE immediately
run  in  1  level; IDLE->FETCH0 when high
ir  in  32  IR register contents; opc=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15]
mem_ready  in  1  memory access complete this cycle
r_in, r_out  out  NUM_REGS  one-hot register load and drive strobes
hi_in, lo_in, hi_out, lo_out, zhigh_out, zlow_out  out  1 each  HI/LO/Z strobes
pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out, y_in, z_in, c_out  out  1 each  datapath enables
read, mem_write  out  1 each  memory strobes; read also selects memory data into MDR
alu_op  out  13  one-hot {AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT}
busy, halted, illegal  out  1 each  status flags

Behaviour:
- Reset low: state=IDLE; every output is 0; illegal cleared. Takes effect immediately, including mid-instruction and mid-memory-wait. Datapath registers are not touched by this block.
- IDLE: all outputs 0. Go to FETCH0 on run=1, or unconditionally when START_ON_RESET=1.
- FETCH0: inc_pc, pc_in, mar_in. Result: MAR<=PC, PC<=PC+1.
- FETCH1: read, mdr_in. Hold this state and these outputs while mem_ready=0.
- FETCH2: mdr_out, ir_in. Next state DECODE.
- DECODE: no strobes; latches opc. busy=1 in every state except IDLE and HALT.
- Execute states T3..T7, per opcode:
  - R-type (ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011): T3 r_out[rb], y_in; T4 r_out[rc], alu_op, z_in; T5 zlow_out, r_in[ra].
  - Immediate (ADDI 01100, ANDI 01101, ORI 01110): T3 r_out[rb], y_in; T4 c_out, alu_op, z_in; T5 zlow_out, r_in[ra].
  - Unary (NEG 10001, NOT 10010): T3 r_out[rb], alu_op, z_in; T4 zlow_out, r_in[ra].
  - MUL 10000 / DIV 01111: T3 r_out[ra], y_in; T4 r_out[rb], alu_op, z_in; T5 zlow_out, lo_in; T6 zhigh_out, hi_in.
  - LDI 00001: T3 r_out[rb], y_in; T4 c_out, ADD, z_in; T5 zlow_out, r_in[ra].
  - LD 00000: as LDI through T4; T5 zlow_out, mar_in; T6 read, mdr_in (wait on mem_ready); T7 mdr_out, r_in[ra].
  - ST 00010: as LD through T5; T6 r_out[ra], mdr_in; T7 mem_write (wait on mem_ready).
  - MFHI 11000: T3 hi_out, r_in[ra]. MFLO 11001: T3 lo_out, r_in[ra].
  - NOP 11010: no execute states.
  - HALT 11011: enter HALT; halted=1; leave only by reset.
- The last execute state of every opcode returns to FETCH0.
- Invariants: at most one bus driver asserted per cycle; at most one alu_op bit set. mem_ready is ignored outside the wait states.
- A read or write wait has no timeout.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an undefined opcode sets illegal=1 and enters HALT.
- Undefined: an undefined opcode sets illegal=1 for one cycle, executes as NOP, and fetch resumes.

Decomposition:
- Package ctrl_pkg: 5-bit opcode constants, state encoding, alu_op bit indices.
- One natural sub-module, reg_sel_decode: maps a 4-bit field plus enable to a one-hot NUM_REGS vector. Instantiated for r_in and r_out.

Test Plan:
- Reset low for 3 cycles, then run=1 with mem_ready tied high -> FETCH0..FETCH2 strobes on consecutive cycles; busy=1 from the FETCH0 cycle.
- ADD with ra=2, rb=4, rc=5 -> T3 r_out=0x0010 + y_in; T4 r_out=0x0020 + alu_op ADD bit + z_in; T5 r_in=0x0004 + zlow_out.
- LD with mem_ready held low 4 cycles in T6 -> read and mdr_in held 5 cycles; T7 r_in[ra] follows the ready cycle.
- MUL ra=3, rb=1 -> lo_in in T5 and hi_in in T6, then FETCH0.
- Reset low mid-ST wait -> all outputs 0 immediately; restart fetches cleanly.
- opc=11111 -> illegal=1; HALT with ILLEGAL_TRAP_EN defined, otherwise FETCH0 after DECODE.
